// File: rtl/verirq_ctrl.sv
// verirq_ctrl: pending/mask/edge interrupt controller driving a single core irq.
// Define VERIRQ_ROUND_ROBIN_EN for rotating priority; default is fixed lowest-index.
module verirq_ctrl #(
    parameter int N_SOURCES = 8,
    localparam int ID_W = (N_SOURCES > 1) ? $clog2(N_SOURCES) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [N_SOURCES-1:0] src,
    input  logic                 accept,
    input  logic                 mret,
    output logic                 irq,
    output logic [ID_W-1:0]      irq_id,
    input  logic                 reg_valid,
    input  logic                 reg_write,
    input  logic [1:0]           reg_addr,
    input  logic [31:0]          reg_wdata,
    output logic [31:0]          reg_rdata,
    output logic                 reg_ready
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQUEST,
        S_SERVICING
    } state_t;

    localparam logic [1:0] A_PEND = 2'd0;
    localparam logic [1:0] A_MASK = 2'd1;
    localparam logic [1:0] A_ACT  = 2'd2;
    localparam logic [1:0] A_EDGE = 2'd3;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [N_SOURCES-1:0]  r_pending;
    logic [N_SOURCES-1:0]  r_mask;
    logic [N_SOURCES-1:0]  r_edge;
    logic [N_SOURCES-1:0]  r_src_q;
    logic                  r_act_v;
    logic [ID_W-1:0]       r_act_id;
    logic                  r_irq;
    logic [ID_W-1:0]       r_irq_id;
    logic                  r_ready;
    logic [31:0]           r_rdata;

    logic [N_SOURCES-1:0]  w_sel;
    logic                  w_any;
    logic [ID_W-1:0]       w_pick;
    logic                  w_take;
    logic                  w_ret;
    logic                  w_latch;
    logic                  w_acc;
    logic                  w_wr;
    logic [N_SOURCES-1:0]  w_wdata;
    logic [N_SOURCES-1:0]  w_w1c;
    logic [N_SOURCES-1:0]  w_clr;
    logic [N_SOURCES-1:0]  w_pend_nxt;
    logic [31:0]           w_rd;
    logic                  w_unused_wdata;

    assign w_sel   = r_pending & r_mask;
    assign w_any   = |w_sel;
    assign w_acc   = reg_valid && !r_ready;
    assign w_wr    = w_acc && reg_write;
    assign w_wdata = reg_wdata[N_SOURCES-1:0];
    assign w_w1c   = (w_wr && reg_addr == A_PEND) ? (w_wdata & r_edge) : '0;

    assign w_unused_wdata = ^reg_wdata;

`ifdef VERIRQ_ROUND_ROBIN_EN
    logic [ID_W-1:0] r_ptr;
    logic [ID_W-1:0] w_idx;

    // Scan downward so the first slot after the pointer wins.
    always_comb begin
        w_pick = '0;
        w_idx  = '0;
        for (int k = N_SOURCES; k >= 1; k--) begin
            w_idx = ID_W'((int'(r_ptr) + k) % N_SOURCES);
            if (w_sel[w_idx]) begin
                w_pick = w_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= ID_W'(N_SOURCES - 1);
        end else if (w_take) begin
            r_ptr <= r_irq_id;
        end
    end
`else
    always_comb begin
        w_pick = '0;
        for (int i = N_SOURCES - 1; i >= 0; i--) begin
            if (w_sel[i]) begin
                w_pick = ID_W'(i);
            end
        end
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        w_ret       = 1'b0;
        w_latch     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_nxt = S_REQUEST;
                    w_latch     = 1'b1;
                end
            end
            S_REQUEST: begin
                if (enable && accept) begin
                    w_state_nxt = S_SERVICING;
                    w_take      = 1'b1;
                end else if (!w_sel[r_irq_id]) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SERVICING: begin
                if (enable && mret) begin
                    w_state_nxt = S_IDLE;
                    w_ret       = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_clr = '0;
        for (int i = 0; i < N_SOURCES; i++) begin
            w_clr[i] = w_take && (r_irq_id == ID_W'(i));
        end
    end

    // A new rising edge outranks both W1C and the accept-time clear.
    always_comb begin
        w_pend_nxt = src;
        for (int i = 0; i < N_SOURCES; i++) begin
            if (r_edge[i]) begin
                w_pend_nxt[i] = (src[i] & ~r_src_q[i])
                              | (r_pending[i] & ~w_w1c[i] & ~w_clr[i]);
            end
        end
    end

    always_comb begin
        w_rd = '0;
        unique case (reg_addr)
            A_PEND: w_rd[N_SOURCES-1:0] = r_pending;
            A_MASK: w_rd[N_SOURCES-1:0] = r_mask;
            A_ACT: begin
                w_rd[31]       = r_act_v;
                w_rd[ID_W-1:0] = r_act_id;
            end
            A_EDGE: w_rd[N_SOURCES-1:0] = r_edge;
            default: w_rd = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_pending <= '0;
            r_mask    <= '0;
            r_edge    <= '0;
            r_src_q   <= '0;
            r_act_v   <= 1'b0;
            r_act_id  <= '0;
            r_irq     <= 1'b0;
            r_irq_id  <= '0;
            r_ready   <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pend_nxt;
            r_src_q   <= src;
            r_irq     <= (w_state_nxt == S_REQUEST);
            if (w_latch) begin
                r_irq_id <= w_pick;
            end
            if (w_take) begin
                r_act_v  <= 1'b1;
                r_act_id <= r_irq_id;
            end else if (w_ret) begin
                r_act_v <= 1'b0;
            end
            if (w_wr && reg_addr == A_MASK) begin
                r_mask <= w_wdata;
            end
            if (w_wr && reg_addr == A_EDGE) begin
                r_edge <= w_wdata;
            end
            r_ready <= w_acc;
            r_rdata <= w_acc ? w_rd : 32'd0;
        end
    end

    assign irq       = r_irq;
    assign irq_id    = r_irq_id;
    assign reg_ready = r_ready;
    assign reg_rdata = r_rdata;

endmodule

// File: tb/tb_verirq_ctrl.sv
// tb_verirq_ctrl: directed scenarios plus random traffic against a cycle model.
// Model tracks registers and service state as plain bits/ints.
module tb_verirq_ctrl;

    localparam int N = 8;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [7:0]  src;
    logic        accept;
    logic        mret;
    logic        irq;
    logic [2:0]  irq_id;
    logic        reg_valid;
    logic        reg_write;
    logic [1:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;
    logic        reg_ready;

    verirq_ctrl #(.N_SOURCES(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .src       (src),
        .accept    (accept),
        .mret      (mret),
        .irq       (irq),
        .irq_id    (irq_id),
        .reg_valid (reg_valid),
        .reg_write (reg_write),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        .reg_ready (reg_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Model state: 0 idle, 1 requesting, 2 in service.
    bit [7:0]  m_pend, m_mask, m_edge, m_prev;
    int        m_st, m_id, m_act_id, m_ptr;
    bit        m_act_v, m_irq, m_rdy;
    bit [31:0] m_rdata;

    function automatic int pick(bit [7:0] s, int ptr);
`ifdef VERIRQ_ROUND_ROBIN_EN
        for (int k = 1; k <= N; k++) begin
            if (s[(ptr + k) % N]) return (ptr + k) % N;
        end
`else
        for (int i = 0; i < N; i++) begin
            if (s[i]) return i;
        end
`endif
        return 0;
    endfunction

    function automatic bit [31:0] model_read(int a);
        bit [31:0] r;
        r = 0;
        case (a)
            0: r[7:0] = m_pend;
            1: r[7:0] = m_mask;
            2: begin r[31] = m_act_v; r[2:0] = 3'(m_act_id); end
            default: r[7:0] = m_edge;
        endcase
        return r;
    endfunction

    task automatic tick();
        bit [7:0]  sel, np, nm, ne, w1c;
        int        nst, nid, naid, nptr;
        bit        nav, take, nrdy;
        bit [31:0] nrd;
        if (reset) begin
            np = 0; nm = 0; ne = 0; nst = 0; nid = 0; naid = 0;
            nptr = N - 1; nav = 0; nrdy = 0; nrd = 0;
        end else begin
            sel  = m_pend & m_mask;
            take = (m_st == 1) && enable && accept;
            w1c  = (reg_valid && !m_rdy && reg_write && reg_addr == 2'd0)
                   ? reg_wdata[7:0] : 8'd0;
            for (int i = 0; i < N; i++) begin
                if (m_edge[i])
                    np[i] = (src[i] && !m_prev[i]) ||
                            (m_pend[i] && !w1c[i] && !(take && m_id == i));
                else
                    np[i] = src[i];
            end
            nm = m_mask; ne = m_edge; nst = m_st; nid = m_id;
            naid = m_act_id; nav = m_act_v; nptr = m_ptr;
            if (m_st == 0) begin
                if (sel != 0) begin nst = 1; nid = pick(sel, m_ptr); end
            end else if (m_st == 1) begin
                if (take) begin
                    nst = 2; nav = 1; naid = m_id; nptr = m_id;
                end else if (!sel[m_id]) begin
                    nst = 0;
                end
            end else if (enable && mret) begin
                nst = 0; nav = 0;
            end
            nrdy = 0; nrd = 0;
            if (reg_valid && !m_rdy) begin
                nrdy = 1;
                nrd  = model_read(int'(reg_addr));
                if (reg_write && reg_addr == 2'd1) nm = reg_wdata[7:0];
                if (reg_write && reg_addr == 2'd3) ne = reg_wdata[7:0];
            end
        end
        @(posedge clk);
        #1;
        m_prev  = reset ? 8'd0 : src;
        m_pend  = np; m_mask = nm; m_edge = ne; m_st = nst; m_id = nid;
        m_act_id = naid; m_act_v = nav; m_ptr = nptr;
        m_rdy   = nrdy; m_rdata = nrd; m_irq = (nst == 1);
        check("irq", 32'(irq), 32'(m_irq));
        check("irq_id", 32'(irq_id), 32'(m_id));
        check("ready", 32'(reg_ready), 32'(m_rdy));
        if (m_rdy) check("rdata", reg_rdata, m_rdata);
    endtask

    task automatic do_reset();
        reset = 1; accept = 0; mret = 0; reg_valid = 0; enable = 1;
        tick(); tick();
        reset = 0;
    endtask

    task automatic reg_wr(int a, bit [31:0] d);
        reg_valid = 1; reg_write = 1; reg_addr = 2'(a); reg_wdata = d;
        tick();
        reg_valid = 0;
        tick();
    endtask

    task automatic reg_rd(int a, output logic [31:0] v);
        reg_valid = 1; reg_write = 0; reg_addr = 2'(a); reg_wdata = 0;
        tick();
        v = reg_rdata;
        reg_valid = 0;
        tick();
    endtask

    task automatic wait_irq(int max);
        int n = 0;
        while (!irq && n < max) begin
            tick();
            n++;
        end
        check("wait_irq", 32'(irq), 32'd1);
    endtask

    initial begin
        logic [31:0] v;
        int exp_id;
        src = 0; reset = 1; enable = 1; accept = 0; mret = 0;
        reg_valid = 0; reg_write = 0; reg_addr = 0; reg_wdata = 0;

        do_reset();
        check("rst_irq", 32'(irq), 0);
        check("rst_rdata", reg_rdata, 0);

        // Edge pulse on source 0, then accept.
        reg_wr(1, 32'hFF);
        reg_wr(3, 32'h01);
        src = 8'h01; tick();
        src = 8'h00; tick();
        check("s1_irq", 32'(irq), 1);
        check("s1_id", 32'(irq_id), 0);
        accept = 1; tick(); accept = 0;
        check("s1_acc_irq", 32'(irq), 0);
        reg_rd(2, v);
        check("s1_active", v, 32'h8000_0000);
        reg_rd(0, v);
        check("s1_pend0", 32'(v[0]), 0);
        mret = 1; tick(); mret = 0; tick();

        // Two level sources, service 3 then 5.
        do_reset();
        reg_wr(1, 32'h28);
        src = 8'h28;
        wait_irq(10);
        check("s2_id3", 32'(irq_id), 3);
        accept = 1; tick(); accept = 0;
        src = 8'h20; tick();
        mret = 1; tick(); mret = 0;
        tick();
        check("s2_irq", 32'(irq), 1);
        check("s2_id5", 32'(irq_id), 5);

        // Masking a requesting source drops it; accept in the same cycle wins.
        reg_wr(1, 32'h00);
        check("s3_drop", 32'(irq), 0);
        reg_wr(1, 32'h20);
        wait_irq(10);
        reg_valid = 1; reg_write = 1; reg_addr = 2'd1; reg_wdata = 0;
        accept = 1; tick();
        accept = 0; reg_valid = 0;
        check("s3_acc_irq", 32'(irq), 0);
        tick();
        reg_rd(2, v);
        check("s3_active", v, 32'h8000_0005);
        mret = 1; tick(); mret = 0; tick();

        // New edge beats a simultaneous W1C; a plain W1C clears.
        do_reset();
        reg_wr(3, 32'h01);
        src = 8'h01; tick();
        src = 8'h00; tick();
        src = 8'h01;
        reg_valid = 1; reg_write = 1; reg_addr = 2'd0; reg_wdata = 32'h01;
        tick();
        reg_valid = 0; src = 8'h00;
        tick();
        reg_rd(0, v);
        check("s4_set_wins", 32'(v[0]), 1);
        reg_wr(0, 32'h01);
        reg_rd(0, v);
        check("s4_w1c", 32'(v[0]), 0);

        // enable gating, then reset while servicing.
        do_reset();
        reg_wr(1, 32'h04);
        src = 8'h04;
        wait_irq(10);
        enable = 0; accept = 1; tick();
        check("s5_en_low", 32'(irq), 1);
        enable = 1; tick(); accept = 0;
        check("s5_serv", 32'(irq), 0);
        reg_valid = 1; reg_write = 0; reg_addr = 2'd2; tick();
        reset = 1; tick();
        reset = 0; reg_valid = 0;
        check("s5_rst_id", 32'(irq_id), 0);
        check("s5_rst_rdy", 32'(reg_ready), 0);
        check("s5_rst_rd", reg_rdata, 0);
        src = 0;

        // Two always-pending sources: arbitration order.
        do_reset();
        reg_wr(1, 32'h03);
        src = 8'h03;
        for (int k = 0; k < 4; k++) begin
            wait_irq(10);
`ifdef VERIRQ_ROUND_ROBIN_EN
            exp_id = k % 2;
`else
            exp_id = 0;
`endif
            check("arb_id", 32'(irq_id), 32'(exp_id));
            accept = 1; tick(); accept = 0;
            mret = 1; tick(); mret = 0;
        end

        // Random traffic.
        do_reset();
        src = 0;
        for (int c = 0; c < 4000; c++) begin
            reset     = ($urandom_range(0, 599) == 0);
            enable    = ($urandom_range(0, 7) != 0);
            src       = src ^ 8'($urandom & $urandom & $urandom);
            accept    = ($urandom_range(0, 2) == 0);
            mret      = ($urandom_range(0, 3) == 0);
            reg_valid = ($urandom_range(0, 2) == 0);
            reg_write = $urandom_range(0, 1) == 1;
            reg_addr  = 2'($urandom_range(0, 3));
            reg_wdata = $urandom;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/verirq_ctrl.md
# verirq_ctrl

Interrupt controller feeding the single `irq` input of the Vermicel branch unit. Collects `N_SOURCES` interrupt lines, holds pending/mask/edge state, selects one source by priority, raises `irq` to the core and tracks the core's accept/MRET handshake so only one interrupt is in service at a time. Software configures it through a small word-wide register port on the core's memory bus.

## Interface
- `N_SOURCES`, default 8: number of interrupt lines, 1..32. `ID_W` = max(1, $clog2(N_SOURCES)).
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  core enable; `accept` and `mret` are ignored when low.
- `src`  in  N_SOURCES  interrupt lines, synchronous to `clk`.
- `accept`  in  1  core entered exception state due to `irq` this cycle.
- `mret`  in  1  core executed MRET this cycle.
- `irq`  out  1  interrupt request to the branch unit; registered.
- `irq_id`  out  ID_W  id of the requested or in-service source; registered.
- `reg_valid`  in  1  register access request.
- `reg_write`  in  1  1 = write, 0 = read.
- `reg_addr`  in  2  register index.
- `reg_wdata`  in  32  write data.
- `reg_rdata`  out  32  read data, valid with `reg_ready`.
- `reg_ready`  out  1  access completion pulse.

## Operation
- Registers (bits above N_SOURCES read 0, writes ignored): 0 PENDING (R; W1C, edge sources only); 1 MASK (RW, 1 = enabled); 2 ACTIVE (R: bit 31 = in service, bits ID_W-1:0 = active id); 3 EDGE (RW, 1 = rising-edge source, 0 = level).
- Level source: PENDING bit <= `src` bit every cycle. Edge source: bit set when `src` high and previous-cycle `src` low; stays set until W1C or accept. Set wins over simultaneous W1C.
- Selectable = PENDING & MASK. Fixed priority: lowest index wins.
- FSM:
  - IDLE: selectable != 0 -> REQUEST, latch selected id into `irq_id`.
  - REQUEST: `irq` = 1. `enable && accept` -> SERVICING; ACTIVE <= {1, `irq_id`}; clear PENDING[`irq_id`] if edge. Else if latched id's bit no longer selectable -> IDLE. Accept wins over drop in the same cycle. Higher-priority arrivals do not replace the latched id.
  - SERVICING: `irq` = 0. `enable && mret` -> IDLE; ACTIVE bit 31 <= 0 (id kept).
- `accept` outside REQUEST and `mret` outside SERVICING are ignored.
- Writing EDGE does not alter PENDING contents; level bits resample next cycle.

## Timing
- Reset values: `irq` 0, `irq_id` 0, `reg_ready` 0, `reg_rdata` 0, PENDING/MASK/EDGE/ACTIVE 0, FSM IDLE, previous-`src` 0.
- Edge on `src` in cycle t -> PENDING set in t+1 -> FSM REQUEST and `irq` = 1 in t+2.
- `accept` in cycle t -> `irq` = 0 in t+1.
- `mret` in cycle t -> IDLE in t+1; a still-selectable source raises `irq` in t+2.
- Register access: `reg_valid` in cycle t -> `reg_ready` = 1 with `reg_rdata` in t+1, one cycle. Write effect is visible from t+1. Reads return pre-write state when they coincide with an update. `reg_valid` is ignored while `reg_ready` is high (one outstanding access).
- Reset in any state returns to reset values on the next edge. An in-flight access is dropped and `irq` is deasserted.

## Configuration
- `VERIRQ_ROUND_ROBIN_EN` defined: rotating priority. A pointer (reset N_SOURCES-1) holds the last accepted id. The search starts at pointer+1 and wraps modulo N_SOURCES. The pointer updates on accept.
- Undefined: fixed lowest-index priority. No pointer register.

## Test plan
- Reset, MASK=0xFF, EDGE=0x01, pulse `src[0]` at t -> `irq`=1, `irq_id`=0 at t+2. Accept -> `irq`=0, ACTIVE=0x8000_0000, PENDING bit0=0.
- `src[3]` and `src[5]` level-high, MASK=0x28 -> `irq_id`=3. Accept, MRET with `src[3]` dropped -> `irq_id`=5 two cycles after MRET.
- In REQUEST, write MASK=0 -> `irq` low next cycle, FSM IDLE. Repeat with `accept` in the same cycle as the write -> SERVICING, ACTIVE valid.
- Edge source pending, W1C PENDING=0x01 in the same cycle as a new edge -> bit stays set.
- `enable`=0 with `accept`=1 -> stays REQUEST, `irq`=1. Reset asserted in SERVICING -> all outputs 0 next cycle.
- With `VERIRQ_ROUND_ROBIN_EN`: sources 0 and 1 permanently level-high -> accepted ids alternate 0,1,0,1. Without it -> always 0.
